// File: rtl/const_div_pkg.sv
// Shared types and elaboration helpers for the iterative divide-by-constant unit.
// Derives digit count and remainder width, and validates the divisor/digit pairing.
package const_div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int calc_n(input int w, input int k);
    return (w + k - 1) / k;
  endfunction

  function automatic int calc_rw(input int d);
    return clog2(d);
  endfunction

  // The digit step relies on r*2^K + digit < D*2^K, so D must fit in one digit.
  function automatic bit cfg_ok(input int d, input int k);
    return (d % 2 == 1) && (d >= 3) && (d < (1 << k));
  endfunction

endpackage

// File: rtl/const_div_digit.sv
// One radix-2^K long-division step by the constant D: {r_in, d_in} -> quotient digit and remainder.
// Constant divisor lets synthesis reduce this to a small lookup.
module const_div_digit #(
  parameter int D  = 5,
  parameter int K  = 6,
  parameter int RW = 3
) (
  input  logic [RW-1:0] r_in,
  input  logic [K-1:0]  d_in,
  output logic [K-1:0]  q_out,
  output logic [RW-1:0] r_out
);

  localparam int VW = RW + K;

  logic [VW-1:0] v;

  assign v     = {r_in, d_in};
  // Since r_in < D the quotient always fits in K bits; truncation drops only zeros.
  assign q_out = K'(v / VW'(D));
  assign r_out = RW'(v % VW'(D));

endmodule

// File: rtl/const_div_iter.sv
// Iterative unsigned divide of a W-bit operand by odd constant D, one K-bit digit per cycle, MSB first.
// Valid/ready on both sides; result is held in DONE until the consumer takes it.
module const_div_iter
  import const_div_pkg::*;
#(
  parameter int  W  = 64,
  parameter int  D  = 5,
  parameter int  K  = 6,
  localparam int RW = calc_rw(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  X,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Q,
  output logic [RW-1:0] R
);

  localparam int N  = calc_n(W, K);
  localparam int NK = N * K;
  localparam int SW = clog2(N + 1);

  if (!cfg_ok(D, K)) begin : g_cfg_err
    $error("const_div_iter: D must be odd with 3 <= D < 2**K");
  end

  state_e        state_q, state_d;
  logic [NK-1:0] op_q, op_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [RW-1:0] r_q, r_d;
  logic [SW-1:0] step_q, step_d;

  logic [K-1:0]  digit;
  logic [K-1:0]  qd;
  logic [RW-1:0] r_next;

  // Operand shifts left each step, so the current digit is always the top K bits.
  assign digit = op_q[NK-1 -: K];

  const_div_digit #(
    .D  (D),
    .K  (K),
    .RW (RW)
  ) u_digit (
    .r_in  (r_q),
    .d_in  (digit),
    .q_out (qd),
    .r_out (r_next)
  );

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    quo_d   = quo_q;
    r_d     = r_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = NK'(X);
          r_d     = '0;
          step_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        op_d   = op_q << K;
        quo_d  = W'({quo_q, qd});
        r_d    = r_next;
        step_d = step_q + 1'b1;
        if (step_q == SW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      quo_q   <= '0;
      r_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      quo_q   <= quo_d;
      r_q     <= r_d;
      step_q  <= step_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = quo_q;
  assign R         = r_q;

endmodule

// File: tb/tb_const_div_iter.sv
// Directed bench for const_div_iter: default build (64/5/6) and a 32/3/4 variant side by side.
// Expected quotients and remainders are hand-computed or taken from plain integer division.
module tb_const_div_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_x, a_q;
  logic [2:0]  a_r;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_x, b_q;
  logic [1:0]  b_r;

  int n_checks = 0;
  int n_fail   = 0;

  const_div_iter #(.W(64), .D(5), .K(6)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .X         (a_x),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .Q         (a_q),
    .R         (a_r)
  );

  const_div_iter #(.W(32), .D(3), .K(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .X         (b_x),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .Q         (b_q),
    .R         (b_r)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_a(input logic [63:0] x);
    int g;
    @(negedge clk);
    a_x = x;
    a_in_valid = 1'b1;
    g = 0;
    while (!a_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_x = ~x;
  endtask

  task automatic wait_a(input string tag, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!a_out_valid && lat < 200);
    if (!a_out_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic op_a(input string tag, input logic [63:0] x, input logic [63:0] eq,
                      input logic [2:0] er, output int lat);
    start_a(x);
    wait_a(tag, lat);
    check({tag, "_q"}, a_q, eq);
    check({tag, "_r"}, a_r, er);
  endtask

  task automatic release_a();
    @(negedge clk);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic op_b(input string tag, input logic [31:0] x, input logic [31:0] eq,
                      input logic [1:0] er, output int lat);
    int g;
    @(negedge clk);
    b_x = x;
    b_in_valid = 1'b1;
    g = 0;
    while (!b_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_x = ~x;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!b_out_valid && lat < 200);
    if (!b_out_valid) check({tag, "_timeout"}, 0, 1);
    check({tag, "_q"}, b_q, eq);
    check({tag, "_r"}, b_r, er);
    @(negedge clk);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] hold_q;
    logic [2:0]  hold_r;
    logic [63:0] rx;
    logic [31:0] ry;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_x = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_x = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_q", a_q, 0);
    check("rst_a_r", a_r, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_q", b_q, 0);

    op_a("zero", 64'd0, 64'd0, 3'd0, lat);
    check("zero_lat", lat, 11);
    release_a();

    op_a("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333_3333_3333_3333, 3'd0, lat);
    release_a();
    op_a("ones_m1", 64'hFFFF_FFFF_FFFF_FFFE, 64'h3333_3333_3333_3332, 3'd4, lat);
    release_a();
    op_a("four", 64'd4, 64'd0, 3'd4, lat);
    release_a();
    op_a("five", 64'd5, 64'd1, 3'd0, lat);
    release_a();

    // Offer a new operand on the very edge DONE is left: it must wait for IDLE.
    op_a("seven", 64'd7, 64'd1, 3'd2, lat);
    @(negedge clk);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_x         = 64'd999;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    check("exit_not_accepted", a_in_ready, 1);
    check("exit_out_valid", a_out_valid, 0);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    check("accepted_next", a_in_ready, 0);
    wait_a("n999", lat);
    check("n999_lat", lat, 11);
    check("n999_q", a_q, 64'd199);
    check("n999_r", a_r, 3'd4);
    release_a();

    // Backpressure: result must be frozen while the consumer stalls.
    op_a("bp", 64'd1000003, 64'd200000, 3'd3, lat);
    hold_q = a_q;
    hold_r = a_r;
    a_in_valid = 1'b1;
    a_x = 64'd42;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_q_stable", a_q, 64'd200000);
      check("bp_r_stable", a_r, 3'd3);
      check("bp_in_ready", a_in_ready, 0);
      check("bp_out_valid", a_out_valid, 1);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("bp_drop_valid", a_out_valid, 0);
    check("bp_in_ready_back", a_in_ready, 1);
    check("idle_keeps_q", a_q, hold_q);
    check("idle_keeps_r", a_r, hold_r);

    // Abort mid-operation at step 5.
    start_a(64'hDEAD_BEEF_0123_4567);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out_valid", a_out_valid, 0);
    check("abort_in_ready", a_in_ready, 1);
    check("abort_q", a_q, 0);
    check("abort_r", a_r, 0);
    repeat (15) @(negedge clk);
    check("abort_no_result", a_out_valid, 0);
    op_a("after_abort", 64'd123, 64'd24, 3'd3, lat);
    release_a();

    op_b("b_100", 32'd100, 32'd33, 2'd1, lat);
    check("b_100_lat", lat, 8);
    op_b("b_ones", 32'hFFFF_FFFF, 32'h5555_5555, 2'd0, lat);
    op_b("b_two", 32'd2, 32'd0, 2'd2, lat);

    for (int i = 0; i < 100; i++) begin
      rx = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op_a("rand_a", rx, rx / 64'd5, 3'(rx % 64'd5), lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_a();
    end
    for (int i = 0; i < 100; i++) begin
      ry = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op_b("rand_b", ry, ry / 32'd3, 2'(ry % 32'd3), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
